// File: rtl/image_memory_arbiter.sv
// Round-robin arbiter sharing one image memory port between a single-beat CPU
// path and an incrementing, wrap-around DMA read burst engine.
module image_memory_arbiter #(
  parameter int AW        = 18,
  parameter int DW        = 8,
  parameter int MEM_DEPTH = 160000,
  parameter int MAX_BURST = 16,
  parameter int LW        = $clog2(MAX_BURST) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_a,
  input  logic [DW-1:0] cpu_wd,
  output logic          cpu_gnt,
  output logic          cpu_err,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rd,
  input  logic          dma_req,
  input  logic [AW-1:0] dma_a,
  input  logic [LW-1:0] dma_len,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rd,
  output logic          dma_done,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  // Handshake: a requester holds req and its qualifiers until it sees its
  // one-cycle gnt; a request still high in the cycle after gnt is a new one.
  typedef enum logic [1:0] {IDLE, CPU, BURST} state_t;

  state_t        state;
  logic          last_dma;
  logic [LW-1:0] beat_cnt;
  logic          cpu_is_read;
  logic          cpu_in_range;

  logic          cpu_in;
  logic          dma_pick;
  logic          cpu_pick;
  logic [AW-1:0] next_a;

  assign cpu_in   = (cpu_a < AW'(MEM_DEPTH));
  // On a tie the requester not served last wins.
  assign dma_pick = dma_req && (!cpu_req || !last_dma);
  assign cpu_pick = cpu_req && !dma_pick;
  assign next_a   = (mem_a == AW'(MEM_DEPTH - 1)) ? '0 : mem_a + 1'b1;

  assign cpu_rd = (cpu_rvalid && cpu_in_range) ? mem_rd : '0;
  assign dma_rd = dma_rvalid ? mem_rd : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_dma     <= 1'b1;
      beat_cnt     <= '0;
      cpu_is_read  <= 1'b0;
      cpu_in_range <= 1'b0;
      cpu_gnt      <= 1'b0;
      cpu_err      <= 1'b0;
      cpu_rvalid   <= 1'b0;
      dma_gnt      <= 1'b0;
      dma_rvalid   <= 1'b0;
      dma_done     <= 1'b0;
      mem_we       <= 1'b0;
      mem_a        <= '0;
      mem_wd       <= '0;
    end else begin
      cpu_gnt    <= 1'b0;
      cpu_err    <= 1'b0;
      cpu_rvalid <= 1'b0;
      dma_gnt    <= 1'b0;
      dma_rvalid <= 1'b0;
      dma_done   <= 1'b0;
      mem_we     <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_pick) begin
            state        <= CPU;
            mem_a        <= cpu_a;
            mem_wd       <= cpu_wd;
            mem_we       <= cpu_we & cpu_in;
            cpu_gnt      <= 1'b1;
            cpu_err      <= ~cpu_in;
            cpu_is_read  <= ~cpu_we;
            cpu_in_range <= cpu_in;
            last_dma     <= 1'b0;
          end else if (dma_pick) begin
            dma_gnt  <= 1'b1;
            last_dma <= 1'b1;
            // Zero-length burst completes immediately without touching memory.
            if (dma_len == '0) begin
              dma_done <= 1'b1;
            end else begin
              state    <= BURST;
              mem_a    <= dma_a;
              beat_cnt <= dma_len - 1'b1;
            end
          end
        end
        CPU: begin
          cpu_rvalid <= cpu_is_read;
          state      <= IDLE;
        end
        BURST: begin
          dma_rvalid <= 1'b1;
          if (beat_cnt == '0) begin
            dma_done <= 1'b1;
            state    <= IDLE;
          end else begin
            beat_cnt <= beat_cnt - 1'b1;
            mem_a    <= next_a;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_image_memory_arbiter.sv
// Directed bench for image_memory_arbiter with a one-cycle-latency memory model.
module tb_image_memory_arbiter;
  localparam int AW = 18;
  localparam int DW = 8;
  localparam int DEPTH = 160000;

  logic          clk;
  logic          rst_n;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_a;
  logic [DW-1:0] cpu_wd;
  logic          cpu_gnt, cpu_err, cpu_rvalid;
  logic [DW-1:0] cpu_rd;
  logic          dma_req;
  logic [AW-1:0] dma_a;
  logic [4:0]    dma_len;
  logic          dma_gnt, dma_rvalid, dma_done;
  logic [DW-1:0] dma_rd;
  logic          mem_we;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;

  logic [DW-1:0] mem [0:DEPTH-1];

  int checks = 0;
  int failures = 0;

  image_memory_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_wd(cpu_wd),
    .cpu_gnt(cpu_gnt), .cpu_err(cpu_err), .cpu_rvalid(cpu_rvalid), .cpu_rd(cpu_rd),
    .dma_req(dma_req), .dma_a(dma_a), .dma_len(dma_len),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rd(dma_rd), .dma_done(dma_done),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input int a);
    return 8'(a) ^ 8'(a >> 8) ^ 8'h5A;
  endfunction

  // memory controller model: read data one cycle after address
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] <= pat(i);
  end
  always @(posedge clk) begin
    if (int'(mem_a) < DEPTH) mem_rd <= mem[mem_a];
    else mem_rd <= 8'hEE;
    if (mem_we && int'(mem_a) < DEPTH) mem[mem_a] <= mem_wd;
  end

  // driver helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_zero"}, 32'({cpu_gnt, cpu_err, cpu_rvalid, cpu_rd, dma_gnt, dma_rvalid,
                               dma_done, dma_rd, mem_we, mem_a, mem_wd}), 32'd0);
  endtask

  task automatic cpu_set(input logic we, input int a, input logic [7:0] wd);
    cpu_req = 1'b1; cpu_we = we; cpu_a = AW'(a); cpu_wd = wd;
  endtask

  logic saw;

  initial begin
    rst_n = 1'b0; cpu_req = 0; cpu_we = 0; cpu_a = '0; cpu_wd = '0;
    dma_req = 0; dma_a = '0; dma_len = '0;
    tick(); tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // CPU write 0xA5 to 39999
    cpu_set(1'b1, 39999, 8'hA5);
    tick();
    chk("wr_gnt", 32'(cpu_gnt), 1);
    chk("wr_we", 32'(mem_we), 1);
    chk("wr_a", 32'(mem_a), 39999);
    chk("wr_wd", 32'(mem_wd), 32'hA5);
    chk("wr_err", 32'(cpu_err), 0);
    cpu_req = 0;
    tick();
    chk("wr_after", 32'({cpu_gnt, mem_we, cpu_rvalid}), 0);

    // CPU read 40000 (in range)
    cpu_set(1'b0, 40000, 8'h00);
    tick();
    chk("rd40000_gnt", 32'({cpu_gnt, cpu_err, mem_we}), 32'b100);
    chk("rd40000_a", 32'(mem_a), 40000);
    cpu_req = 0;
    tick();
    chk("rd40000_rv", 32'(cpu_rvalid), 1);
    chk("rd40000_rd", 32'(cpu_rd), 32'(pat(40000)));

    // CPU read 39999 returns written byte
    cpu_set(1'b0, 39999, 8'h00);
    tick();
    chk("rd39999_gnt", 32'(cpu_gnt), 1);
    cpu_req = 0;
    tick();
    chk("rd39999_rv", 32'(cpu_rvalid), 1);
    chk("rd39999_rd", 32'(cpu_rd), 32'hA5);

    // CPU read out of range
    cpu_set(1'b0, 160000, 8'h00);
    tick();
    chk("oor_rd_gnt", 32'({cpu_gnt, cpu_err, mem_we}), 32'b110);
    cpu_req = 0;
    tick();
    chk("oor_rd_rv", 32'(cpu_rvalid), 1);
    chk("oor_rd_rd", 32'(cpu_rd), 0);
    chk("oor_rd_err_pulse", 32'(cpu_err), 0);

    // CPU write out of range must not write
    cpu_set(1'b1, 170000, 8'h33);
    tick();
    chk("oor_wr_gnt", 32'({cpu_gnt, cpu_err, mem_we}), 32'b110);
    cpu_req = 0;
    tick();
    chk("oor_wr_rv", 32'(cpu_rvalid), 0);

    // DMA wrap-around burst
    dma_req = 1; dma_a = AW'(159998); dma_len = 5'd4;
    tick();
    chk("dwrap_gnt", 32'({dma_gnt, dma_rvalid, mem_we}), 32'b100);
    chk("dwrap_a0", 32'(mem_a), 159998);
    dma_req = 0;
    tick();
    chk("dwrap_a1", 32'(mem_a), 159999);
    chk("dwrap_b0", 32'({dma_rvalid, dma_rd}), 32'({1'b1, pat(159998)}));
    tick();
    chk("dwrap_a2", 32'(mem_a), 0);
    chk("dwrap_b1", 32'({dma_rvalid, dma_rd}), 32'({1'b1, pat(159999)}));
    tick();
    chk("dwrap_a3", 32'(mem_a), 1);
    chk("dwrap_b2", 32'({dma_rvalid, dma_rd, dma_done}), 32'({1'b1, pat(0), 1'b0}));
    tick();
    chk("dwrap_b3", 32'({dma_rvalid, dma_rd, dma_done}), 32'({1'b1, pat(1), 1'b1}));
    tick();
    chk("dwrap_end", 32'({dma_rvalid, dma_done, dma_gnt}), 0);

    // zero-length DMA
    dma_req = 1; dma_a = AW'(777); dma_len = 5'd0;
    tick();
    chk("dz_gnt_done", 32'({dma_gnt, dma_done, dma_rvalid, mem_we}), 32'b1100);
    chk("dz_no_addr", 32'(mem_a), 1);
    dma_req = 0;
    tick();
    chk("dz_after", 32'({dma_gnt, dma_done, dma_rvalid}), 0);

    // tie from reset: CPU first, then 16-beat burst, CPU re-request after it
    rst_n = 0; tick(); rst_n = 1; tick();
    cpu_set(1'b0, 100, 8'h00);
    dma_req = 1; dma_a = AW'(200); dma_len = 5'd16;
    tick();
    chk("tie_cpu_first", 32'({cpu_gnt, dma_gnt}), 32'b10);
    chk("tie_cpu_a", 32'(mem_a), 100);
    cpu_req = 0;
    tick();
    chk("tie_cpu_rd", 32'({cpu_rvalid, cpu_rd}), 32'({1'b1, pat(100)}));
    tick();
    chk("tie_dma_gnt", 32'(dma_gnt), 1);
    chk("tie_dma_a0", 32'(mem_a), 200);
    dma_req = 0;
    cpu_set(1'b0, 300, 8'h00);
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (k <= 15) chk("burst_addr", 32'(mem_a), 32'(200 + k));
      if (k <= 16) begin
        chk("burst_beat", 32'({dma_rvalid, dma_rd}), 32'({1'b1, pat(200 + k - 1)}));
        chk("burst_cpu_wait", 32'(cpu_gnt), 0);
        chk("burst_done", 32'(dma_done), 32'(k == 16));
      end else begin
        chk("cpu_after_burst", 32'(cpu_gnt), 1);
        chk("cpu_after_burst_a", 32'(mem_a), 300);
      end
    end
    cpu_req = 0;
    tick();
    chk("cpu_after_burst_rd", 32'({cpu_rvalid, cpu_rd}), 32'({1'b1, pat(300)}));

    // reset mid-burst after beat 3
    dma_req = 1; dma_a = AW'(500); dma_len = 5'd16;
    tick();
    chk("mr_gnt", 32'(dma_gnt), 1);
    dma_req = 0;
    tick(); tick(); tick();
    chk("mr_beat3", 32'({dma_rvalid, dma_rd}), 32'({1'b1, pat(502)}));
    rst_n = 0;
    #1;
    chk_all_zero("midreset");
    tick(); tick();
    rst_n = 1;
    saw = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (dma_done || dma_rvalid || mem_we) saw = 1'b1;
    end
    chk("mr_no_done", 32'(saw), 0);
    cpu_set(1'b0, 1234, 8'h00);
    tick();
    chk("mr_cpu_gnt", 32'({cpu_gnt, cpu_err}), 32'b10);
    cpu_req = 0;
    tick();
    chk("mr_cpu_rd", 32'({cpu_rvalid, cpu_rd}), 32'({1'b1, pat(1234)}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
